control_unit: RTL and testbench
===============================

# control_unit

Multicycle control FSM that sits directly upstream of the MIPS-subset datapath and drives every one of its control inputs. It consumes the datapath's `opCode`, `funct`, `eqf`, `gtf`, `ov` and `div0` outputs. It sequences fetch, decode, execute, memory access, write-back, the multiply/divide wait and the exception entry. Every output is a pure function of the current state and the current status inputs (Mealy only where the text below says so).

## Interface
- Parameters:
  - `MD_CYCLES`, default 32: number of cycles to wait for DIVMULT before HI/LO are written.
  - `STATE_W`, default 6: width of the state register and the `state` debug port.
- Ports:
  - `clk` in 1: single clock; all state changes occur on its rising edge.
  - `reset` in 1: synchronous, active-high.
  - `opCode`, `funct` in 6 each: IR fields from the datapath.
  - `eqf`, `gtf`, `ov`, `div0` in 1 each: ALU and DIVMULT status flags.
  - `MemCtrl`, `PCCtrl`, `MDCtrl`, `SECtrl`, `ShiftSrc`, `ShiftAmt`, `IRWrite`, `RegWrite`, `ALUOutCtrl`, `EPCCtrl`, `HILOWrite` out 1 each.
  - `IorD`, `ALUSrcA`, `ALUSrcB`, `RegDst`, `LSCtrl`, `SSCtrl`, `ExcptCtrl` out 2 each.
  - `ShiftCtrl`, `PCSrc`, `ALUCtrl` out 3 each.
  - `DataSrc` out 4.
  - `state` out `STATE_W`: current state code, for verification only.

## Operation
- Mux encodings:
  - IorD: 0 PC, 1 ALUResult, 2 ALUOut, 3 exception address.
  - ALUSrcA: 0 PC, 1 A, 2 LS.
  - ALUSrcB: 0 B, 1 constant 4, 2 SE16, 3 SE16<<2.
  - RegDst: 0 rt, 1 rd, 2 r30, 3 r31.
  - DataSrc: 0 ALUOut, 1 LS, 2 HI, 3 LO, 4 SE1(ltf), 5 SE16, 6 SL16, 7 Excep, 8 ShiftReg.
  - PCSrc: 0 ALUResult, 1 ALUOut, 2 jump target, 3 LS, 4 EPC.
  - ALUCtrl: 001 add, 010 sub, 011 and, 111 compare.
  - ExcptCtrl: 0 invalid opcode (vector 253), 1 overflow (254), 2 div0 (255).
  - LSCtrl / SSCtrl: 0 word, 2 byte.
  - MemCtrl: 0 read, 1 write.
  - ShiftCtrl: 000 hold, 001 load, 010 shift left.
- Default: every output is 0 in every state unless listed below.
- Fetch and decode:
  - FETCH1: IorD=0, ALUSrcA=0, ALUSrcB=1, ALUCtrl=add, PCSrc=0, PCCtrl=1 (PC←PC+4).
  - FETCH2: wait for memory.
  - FETCH3: IRWrite=1.
  - DECODE: ALUSrcA=0, ALUSrcB=3, ALUCtrl=add, ALUOutCtrl=1 (branch target). A and B load from the register bank.
- Instruction set, dispatched from DECODE:
  - R-type add/sub/and (funct 0x20/0x22/0x24):
    - EXEC: ALUSrcA=1, ALUSrcB=0, op, ALUOutCtrl=1.
    - WB: RegDst=1, DataSrc=0, RegWrite=1.
  - slt (funct 0x2a): one state with ALUSrcA=1, ALUSrcB=0, ALUCtrl=111, RegDst=1, DataSrc=4, RegWrite=1.
  - jr (funct 0x08): ALUSrcA=1, ALUCtrl=000 (pass A), PCSrc=0, PCCtrl=1.
  - mfhi / mflo (funct 0x10 / 0x12): RegDst=1, DataSrc=2 or 3, RegWrite=1.
  - sll (funct 0x00):
    - SH1: ShiftSrc=1, ShiftCtrl=001.
    - SH2: ShiftAmt=1, ShiftCtrl=010.
    - SH3: RegDst=1, DataSrc=8, RegWrite=1.
  - mult / div (funct 0x18 / 0x1a): MDCtrl=0 or 1, held for the whole sequence.
    - The counter clears in the first wait cycle and counts to `MD_CYCLES`-1.
    - The final cycle asserts HILOWrite=1.
    - div0=1 in the first wait cycle aborts to an exception with ExcptCtrl=2.
  - addi (0x08):
    - EXEC: ALUSrcA=1, ALUSrcB=2, add, ALUOutCtrl=1.
    - WB: RegDst=0, DataSrc=0, RegWrite=1.
  - lw (0x23):
    - Address state: ALUSrcA=1, ALUSrcB=2, add, ALUOutCtrl=1.
    - Two read states with IorD=2.
    - Final state: RegDst=0, DataSrc=1, LSCtrl=0, RegWrite=1.
  - sw (0x2b):
    - Address state: same as lw.
    - Write state: IorD=2, SSCtrl=0, MemCtrl=1.
  - beq / bne (0x04 / 0x05): ALUSrcA=1, ALUSrcB=0, ALUCtrl=111.
    - PCSrc=1, with PCCtrl=eqf for beq or !eqf for bne (Mealy).
  - lui (0x0f): RegDst=0, DataSrc=6, RegWrite=1.
  - j (0x02): PCSrc=2, PCCtrl=1.
  - jal (0x03):
    - First state: ALUSrcA=0, ALUCtrl=000, ALUOutCtrl=1.
    - Second state: RegDst=3, DataSrc=0, RegWrite=1, PCSrc=2, PCCtrl=1.
- Overflow: `ov` is sampled in the EXEC state of add, sub and addi. When ov=1 the write-back is skipped and the FSM enters EXC1 with ExcptCtrl=1.
- Unknown opcode or funct: enter EXC1 with ExcptCtrl=0.
- Exception sequence. The ExcptCtrl value is latched internally and driven throughout EXC1..EXC4.
  - EXC1: ALUSrcA=0, ALUSrcB=1, ALUCtrl=sub, EPCCtrl=1 (EPC←PC-4), IorD=3, MemCtrl=0.
  - EXC2, EXC3: IorD=3, waiting for memory and MDR.
  - EXC4: LSCtrl=2, PCSrc=3, PCCtrl=1. Next state is FETCH1.
- Every terminal state returns to FETCH1.

## Timing
- Reset:
  - While `reset`=1 at a clock edge, the state is forced to RESET and the counter and latched cause clear.
  - All outputs are 0 in RESET.
  - The first cycle after reset is released is FETCH1.
  - Reset asserted mid-instruction or mid-mult wait aborts with no write-back.
- Instruction lengths, counting FETCH1 through the last state:
  - Fetch + decode: 4 cycles.
  - R-type ALU ops, addi: 6 cycles.
  - slt, jr, mfhi, mflo, lui, j, beq, bne: 5 cycles.
  - jal: 6 cycles.
  - sll, sw: 7 cycles.
  - lw: 8 cycles.
  - mult, div: 4 + `MD_CYCLES` cycles.
  - Exception: 4 cycles after the detecting state.
- Status flag sampling:
  - `eqf` and `ov` are only acted on in the states named above; other values are ignored.
  - `gtf` is unused in this subset and must not affect state.
- Write-enable conflicts: RegWrite and MemCtrl=1 are never both 1. PCCtrl=1 and IRWrite=1 are never in the same cycle.

## Test plan
- Reset held for 3 cycles, then released:
  - All outputs are 0 while reset is high.
  - `state` shows FETCH1 on the next cycle, with PCCtrl=1, ALUSrcB=1 and ALUCtrl=001.
- opCode 0, funct 0x20, ov=0:
  - Exactly 6 cycles.
  - RegWrite=1 only in cycle 6, with RegDst=1 and DataSrc=0.
- Same instruction with ov=1 in EXEC:
  - No RegWrite.
  - EXC1 shows EPCCtrl=1, IorD=3 and ExcptCtrl=1.
  - PCSrc=3 with PCCtrl=1 three cycles later.
- beq with eqf=1 → PCCtrl=1, PCSrc=1 in cycle 5. With eqf=0 → PCCtrl stays 0, and the next cycle is FETCH1.
- lw (0x23):
  - IorD=2 in cycles 6–7.
  - DataSrc=1, RegWrite=1 in cycle 8.
- div (funct 0x1a) with `MD_CYCLES`=32:
  - div0=0: HILOWrite=1 exactly once, in cycle 36.
  - div0=1: EXC1 is entered in cycle 6 with ExcptCtrl=2, and HILOWrite never asserts.

Source files
------------

// File: rtl/control_unit_if.sv
// control_unit_if: datapath status flags in, every datapath control line out.
interface control_unit_if #(
    parameter int STATE_W = 6
);
    logic [5:0] opCode, funct;
    logic eqf, gtf, ov, div0;
    logic MemCtrl, PCCtrl, MDCtrl, SECtrl, ShiftSrc, ShiftAmt, IRWrite, RegWrite, ALUOutCtrl, EPCCtrl, HILOWrite;
    logic [1:0] IorD, ALUSrcA, ALUSrcB, RegDst, LSCtrl, SSCtrl, ExcptCtrl;
    logic [2:0] ShiftCtrl, PCSrc, ALUCtrl;
    logic [3:0] DataSrc;
    logic [STATE_W-1:0] state;

    modport master (
        input  opCode, funct, eqf, gtf, ov, div0,
        output MemCtrl, PCCtrl, MDCtrl, SECtrl, ShiftSrc, ShiftAmt, IRWrite, RegWrite, ALUOutCtrl, EPCCtrl,
               HILOWrite, IorD, ALUSrcA, ALUSrcB, RegDst, LSCtrl, SSCtrl, ExcptCtrl, ShiftCtrl, PCSrc, ALUCtrl,
               DataSrc, state
    );
    modport slave (
        output opCode, funct, eqf, gtf, ov, div0,
        input  MemCtrl, PCCtrl, MDCtrl, SECtrl, ShiftSrc, ShiftAmt, IRWrite, RegWrite, ALUOutCtrl, EPCCtrl,
               HILOWrite, IorD, ALUSrcA, ALUSrcB, RegDst, LSCtrl, SSCtrl, ExcptCtrl, ShiftCtrl, PCSrc, ALUCtrl,
               DataSrc, state
    );
endinterface

// File: rtl/control_unit.sv
// control_unit: multicycle FSM sequencing fetch, decode, execute, memory, write-back and exceptions.
module control_unit #(
    parameter int MD_CYCLES = 32,
    parameter int STATE_W = 6
) (
    input logic clk,
    input logic reset,
    control_unit_if.master bus
);
    localparam int CNT_W = $clog2(MD_CYCLES + 1);
    localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MD_CYCLES - 1);

    typedef enum logic [STATE_W-1:0] {
        RESET, FETCH1, FETCH2, FETCH3, DECODE,
        ADD, SUB, AND, RWB, SLT, JR, MFHI, MFLO, SH1, SH2, SH3, MULTW, DIVW,
        ADDI, IWB, LWA, LW1, LW2, LW3, SWA, SWR, SWW, BEQ, BNE, LUI, J, JAL1, JAL2,
        EXC1, EXC2, EXC3, EXC4
    } state_t;

    typedef struct packed {
        logic memCtrl, pcCtrl, mdCtrl, shiftSrc, shiftAmt, irWrite, regWrite, aluOutCtrl, epcCtrl;
        logic [1:0] iorD, aluSrcA, aluSrcB, regDst, lsCtrl, ssCtrl;
        logic [2:0] shiftCtrl, pcSrc, aluCtrl;
        logic [3:0] dataSrc;
    } ctl_t;

    state_t state, nextState;
    ctl_t ctl;
    logic [CNT_W-1:0] cnt, nextCnt;
    logic [1:0] cause, nextCause;
    logic hiloWrite;
    logic unusedGtf;

    function automatic state_t dispatch(logic [5:0] op, logic [5:0] fn);
        state_t s;
        s = EXC1;
        case (op)
            6'h00: case (fn)
                6'h20: s = ADD;
                6'h22: s = SUB;
                6'h24: s = AND;
                6'h2a: s = SLT;
                6'h08: s = JR;
                6'h10: s = MFHI;
                6'h12: s = MFLO;
                6'h00: s = SH1;
                6'h18: s = MULTW;
                6'h1a: s = DIVW;
                default: s = EXC1;
            endcase
            6'h08: s = ADDI;
            6'h23: s = LWA;
            6'h2b: s = SWA;
            6'h04: s = BEQ;
            6'h05: s = BNE;
            6'h0f: s = LUI;
            6'h02: s = J;
            6'h03: s = JAL1;
            default: s = EXC1;
        endcase
        return s;
    endfunction

    // Control word of a state; registered one cycle ahead so outputs come straight from flops.
    function automatic ctl_t decode(state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH1: begin c.aluSrcB = 2'd1; c.aluCtrl = 3'b001; c.pcCtrl = 1'b1; end
            FETCH3: c.irWrite = 1'b1;
            DECODE: begin c.aluSrcB = 2'd3; c.aluCtrl = 3'b001; c.aluOutCtrl = 1'b1; end
            ADD, SUB, AND: begin
                c.aluSrcA = 2'd1;
                c.aluOutCtrl = 1'b1;
                c.aluCtrl = s == ADD ? 3'b001 : s == SUB ? 3'b010 : 3'b011;
            end
            RWB: begin c.regDst = 2'd1; c.regWrite = 1'b1; end
            SLT: begin c.aluSrcA = 2'd1; c.aluCtrl = 3'b111; c.regDst = 2'd1; c.dataSrc = 4'd4; c.regWrite = 1'b1; end
            JR: begin c.aluSrcA = 2'd1; c.pcCtrl = 1'b1; end
            MFHI, MFLO: begin c.regDst = 2'd1; c.dataSrc = s == MFHI ? 4'd2 : 4'd3; c.regWrite = 1'b1; end
            SH1: begin c.shiftSrc = 1'b1; c.shiftCtrl = 3'b001; end
            SH2: begin c.shiftAmt = 1'b1; c.shiftCtrl = 3'b010; end
            SH3: begin c.regDst = 2'd1; c.dataSrc = 4'd8; c.regWrite = 1'b1; end
            DIVW: c.mdCtrl = 1'b1;
            ADDI, LWA, SWA: begin c.aluSrcA = 2'd1; c.aluSrcB = 2'd2; c.aluCtrl = 3'b001; c.aluOutCtrl = 1'b1; end
            IWB: c.regWrite = 1'b1;
            LW1, LW2, SWR: c.iorD = 2'd2;
            LW3: begin c.dataSrc = 4'd1; c.regWrite = 1'b1; end
            SWW: begin c.iorD = 2'd2; c.memCtrl = 1'b1; end
            BEQ, BNE: begin c.aluSrcA = 2'd1; c.aluCtrl = 3'b111; c.pcSrc = 3'd1; end
            LUI: begin c.dataSrc = 4'd6; c.regWrite = 1'b1; end
            J: begin c.pcSrc = 3'd2; c.pcCtrl = 1'b1; end
            JAL1: c.aluOutCtrl = 1'b1;
            JAL2: begin c.regDst = 2'd3; c.regWrite = 1'b1; c.pcSrc = 3'd2; c.pcCtrl = 1'b1; end
            EXC1: begin c.aluSrcB = 2'd1; c.aluCtrl = 3'b010; c.epcCtrl = 1'b1; c.iorD = 2'd3; end
            EXC2, EXC3: c.iorD = 2'd3;
            EXC4: begin c.lsCtrl = 2'd2; c.pcSrc = 3'd3; c.pcCtrl = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nextState = FETCH1;
        nextCnt = cnt;
        nextCause = cause;
        case (state)
            FETCH1: nextState = FETCH2;
            FETCH2: nextState = FETCH3;
            FETCH3: nextState = DECODE;
            DECODE: begin nextState = dispatch(bus.opCode, bus.funct); nextCnt = '0; end
            ADD, SUB, ADDI: begin
                nextState = bus.ov ? EXC1 : state == ADDI ? IWB : RWB;
                nextCause = bus.ov ? 2'd1 : cause;
            end
            AND: nextState = RWB;
            SH1: nextState = SH2;
            SH2: nextState = SH3;
            LWA: nextState = LW1;
            LW1: nextState = LW2;
            LW2: nextState = LW3;
            SWA: nextState = SWR;
            SWR: nextState = SWW;
            JAL1: nextState = JAL2;
            MULTW, DIVW: begin
                nextCnt = cnt + 1'b1;
                nextState = cnt == MD_LAST ? FETCH1 : state;
                if (state == DIVW && cnt == '0 && bus.div0) begin
                    nextState = EXC1;
                    nextCause = 2'd2;
                end
            end
            EXC1: nextState = EXC2;
            EXC2: nextState = EXC3;
            EXC3: nextState = EXC4;
            default: nextState = FETCH1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RESET;
            cnt <= '0;
            cause <= '0;
            ctl <= '0;
            hiloWrite <= 1'b0;
        end else begin
            state <= nextState;
            cnt <= nextCnt;
            cause <= nextState inside {EXC1, EXC2, EXC3, EXC4} ? nextCause : 2'd0;
            ctl <= decode(nextState);
            hiloWrite <= (nextState == MULTW || nextState == DIVW) && nextCnt == MD_LAST;
        end
    end

    assign unusedGtf = bus.gtf;
    assign bus.state = state;
    assign bus.MemCtrl = ctl.memCtrl;
    // Branch decision is the one Mealy output: it follows the live eqf flag.
    assign bus.PCCtrl = ctl.pcCtrl | (state == BEQ & bus.eqf) | (state == BNE & ~bus.eqf);
    assign bus.MDCtrl = ctl.mdCtrl;
    assign bus.SECtrl = 1'b0;
    assign bus.ShiftSrc = ctl.shiftSrc;
    assign bus.ShiftAmt = ctl.shiftAmt;
    assign bus.IRWrite = ctl.irWrite;
    assign bus.RegWrite = ctl.regWrite;
    assign bus.ALUOutCtrl = ctl.aluOutCtrl;
    assign bus.EPCCtrl = ctl.epcCtrl;
    assign bus.HILOWrite = hiloWrite;
    assign bus.IorD = ctl.iorD;
    assign bus.ALUSrcA = ctl.aluSrcA;
    assign bus.ALUSrcB = ctl.aluSrcB;
    assign bus.RegDst = ctl.regDst;
    assign bus.LSCtrl = ctl.lsCtrl;
    assign bus.SSCtrl = ctl.ssCtrl;
    assign bus.ExcptCtrl = cause;
    assign bus.ShiftCtrl = ctl.shiftCtrl;
    assign bus.PCSrc = ctl.pcSrc;
    assign bus.ALUCtrl = ctl.aluCtrl;
    assign bus.DataSrc = ctl.dataSrc;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and randomized instruction streams checked against a per-instruction timing model.
module tb_control_unit;
    localparam int MD = 32;
    localparam int SW = 6;

    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;

    control_unit_if #(.STATE_W(SW)) bus ();
    control_unit #(.MD_CYCLES(MD), .STATE_W(SW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int len, conflicts;
    logic [63:0] rwM, pcM, memwM, hiloM, epcM, iord2M, irM;
    logic [1:0] rdAtRw, excAtEpc, iordAtEpc, excAtPc;
    logic [3:0] dsAtRw;
    logic [2:0] pcSrcLast;

    int eLen;
    logic [63:0] eRw, ePc, eMemw, eHilo, eEpc;
    logic [1:0] eRd, eExc;
    logic [3:0] eDs;
    logic [2:0] ePcSrc;

    function automatic logic [37:0] outs();
        return {bus.MemCtrl, bus.PCCtrl, bus.MDCtrl, bus.SECtrl, bus.ShiftSrc, bus.ShiftAmt, bus.IRWrite,
                bus.RegWrite, bus.ALUOutCtrl, bus.EPCCtrl, bus.HILOWrite, bus.IorD, bus.ALUSrcA, bus.ALUSrcB,
                bus.RegDst, bus.LSCtrl, bus.SSCtrl, bus.ExcptCtrl, bus.ShiftCtrl, bus.PCSrc, bus.ALUCtrl, bus.DataSrc};
    endfunction

    function automatic logic isFetch();
        return bus.PCCtrl && bus.ALUSrcB == 2'd1 && bus.ALUCtrl == 3'b001 && bus.IorD == 2'd0 &&
               bus.PCSrc == 3'd0 && !bus.IRWrite && !bus.EPCCtrl;
    endfunction

    task automatic sample(input int c);
        rwM[c] = bus.RegWrite;
        pcM[c] = bus.PCCtrl;
        memwM[c] = bus.MemCtrl;
        hiloM[c] = bus.HILOWrite;
        epcM[c] = bus.EPCCtrl;
        iord2M[c] = bus.IorD == 2'd2;
        irM[c] = bus.IRWrite;
        if (bus.RegWrite) begin rdAtRw = bus.RegDst; dsAtRw = bus.DataSrc; end
        if (bus.PCCtrl) pcSrcLast = bus.PCSrc;
        if (bus.PCCtrl && bus.PCSrc == 3'd3) excAtPc = bus.ExcptCtrl;
        if (bus.EPCCtrl) begin excAtEpc = bus.ExcptCtrl; iordAtEpc = bus.IorD; end
        if ((bus.RegWrite && bus.MemCtrl) || (bus.PCCtrl && bus.IRWrite)) conflicts++;
    endtask

    // Entered at the negedge of a FETCH1 cycle; leaves at the negedge of the next FETCH1.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic ov5, input logic eqf5, input logic dz5);
        int c;
        bit done;
        {rwM, pcM, memwM, hiloM, epcM, iord2M, irM} = '0;
        {rdAtRw, excAtEpc, iordAtEpc, excAtPc, dsAtRw, pcSrcLast} = '0;
        conflicts = 0;
        bus.opCode = op;
        bus.funct = fn;
        sample(1);
        c = 1;
        done = 0;
        while (!done) begin
            @(posedge clk);
            #1;
            c++;
            bus.ov = c == 5 ? ov5 : 1'($urandom_range(0, 1));
            bus.eqf = c == 5 ? eqf5 : 1'($urandom_range(0, 1));
            bus.div0 = c == 5 ? dz5 : 1'($urandom_range(0, 1));
            bus.gtf = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (isFetch()) done = 1;
            else if (c >= 60) begin
                checks++;
                errors++;
                $display("FAIL timeout: op %0h funct %0h still running after %0d cycles, required to end", op, fn, c);
                done = 1;
            end else sample(c);
        end
        len = c - 1;
    endtask

    // Reference: per-instruction length and the cycle (1 = FETCH1) of each visible event.
    task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic ov5, input logic eqf5, input logic dz5);
        int det, rw;
        logic [1:0] why;
        {eRw, eMemw, eHilo, eEpc} = '0;
        ePc = 64'b10;
        {eRd, eExc, eDs, ePcSrc} = '0;
        det = 0;
        rw = 0;
        why = 2'd0;
        eLen = 5;
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h22: if (ov5) begin det = 5; why = 2'd1; end else begin eLen = 6; rw = 6; eRd = 1; end
                6'h24: begin eLen = 6; rw = 6; eRd = 1; end
                6'h2a: begin rw = 5; eRd = 1; eDs = 4; end
                6'h08: ePc[5] = 1'b1;
                6'h10: begin rw = 5; eRd = 1; eDs = 2; end
                6'h12: begin rw = 5; eRd = 1; eDs = 3; end
                6'h00: begin eLen = 7; rw = 7; eRd = 1; eDs = 8; end
                6'h18: begin eLen = 4 + MD; eHilo[4 + MD] = 1'b1; end
                6'h1a: if (dz5) begin det = 5; why = 2'd2; end else begin eLen = 4 + MD; eHilo[4 + MD] = 1'b1; end
                default: det = 4;
            endcase
        end else begin
            case (op)
                6'h08: if (ov5) begin det = 5; why = 2'd1; end else begin eLen = 6; rw = 6; end
                6'h23: begin eLen = 8; rw = 8; eDs = 1; end
                6'h2b: begin eLen = 7; eMemw[7] = 1'b1; end
                6'h04: if (eqf5) begin ePc[5] = 1'b1; ePcSrc = 1; end
                6'h05: if (!eqf5) begin ePc[5] = 1'b1; ePcSrc = 1; end
                6'h0f: begin rw = 5; eDs = 6; end
                6'h02: begin ePc[5] = 1'b1; ePcSrc = 2; end
                6'h03: begin eLen = 6; rw = 6; eRd = 3; ePc[6] = 1'b1; ePcSrc = 2; end
                default: det = 4;
            endcase
        end
        if (rw != 0) eRw[rw] = 1'b1;
        if (det != 0) begin
            eLen = det + 4;
            eEpc[det + 1] = 1'b1;
            ePc[det + 4] = 1'b1;
            ePcSrc = 3;
            eExc = why;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        {bus.opCode, bus.funct, bus.eqf, bus.gtf, bus.ov, bus.div0} = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (outs() !== '0) begin errors++; $display("FAIL reset_outs: got %h required 0", outs()); end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (!(bus.PCCtrl === 1'b1 && bus.ALUSrcB === 2'd1 && bus.ALUCtrl === 3'b001 && isFetch())) begin
            errors++;
            $display("FAIL reset_fetch1: PCCtrl %b ALUSrcB %0d ALUCtrl %b required 1 1 001", bus.PCCtrl, bus.ALUSrcB, bus.ALUCtrl);
        end
    endtask

    task automatic test_add();
        run_instr(6'h00, 6'h20, 1'b0, 1'b0, 1'b0);
        checks++;
        if (len !== 6) begin errors++; $display("FAIL add_len: got %0d required 6", len); end
        checks++;
        if (rwM !== 64'h40 || rdAtRw !== 2'd1 || dsAtRw !== 4'd0) begin
            errors++;
            $display("FAIL add_wb: RegWrite mask %h RegDst %0d DataSrc %0d required 40 1 0", rwM, rdAtRw, dsAtRw);
        end
    endtask

    task automatic test_overflow();
        run_instr(6'h00, 6'h20, 1'b1, 1'b0, 1'b0);
        checks++;
        if (rwM !== 64'h0) begin errors++; $display("FAIL ovf_nowb: RegWrite mask %h required 0", rwM); end
        checks++;
        if (epcM !== 64'h40 || iordAtEpc !== 2'd3 || excAtEpc !== 2'd1) begin
            errors++;
            $display("FAIL ovf_exc1: EPCCtrl mask %h IorD %0d ExcptCtrl %0d required 40 3 1", epcM, iordAtEpc, excAtEpc);
        end
        checks++;
        if (pcM !== 64'h202 || pcSrcLast !== 3'd3 || excAtPc !== 2'd1 || len !== 9) begin
            errors++;
            $display("FAIL ovf_exc4: PCCtrl mask %h PCSrc %0d ExcptCtrl %0d len %0d required 202 3 1 9", pcM, pcSrcLast, excAtPc, len);
        end
    endtask

    task automatic test_beq();
        run_instr(6'h04, 6'h00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (pcM !== 64'h22 || pcSrcLast !== 3'd1 || len !== 5) begin
            errors++;
            $display("FAIL beq_taken: PCCtrl mask %h PCSrc %0d len %0d required 22 1 5", pcM, pcSrcLast, len);
        end
        run_instr(6'h04, 6'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pcM !== 64'h2 || len !== 5) begin
            errors++;
            $display("FAIL beq_not_taken: PCCtrl mask %h len %0d required 2 5", pcM, len);
        end
    endtask

    task automatic test_lw();
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (iord2M !== 64'hc0) begin errors++; $display("FAIL lw_read: IorD=2 mask %h required c0", iord2M); end
        checks++;
        if (rwM !== 64'h100 || dsAtRw !== 4'd1 || len !== 8) begin
            errors++;
            $display("FAIL lw_wb: RegWrite mask %h DataSrc %0d len %0d required 100 1 8", rwM, dsAtRw, len);
        end
    endtask

    task automatic test_div();
        run_instr(6'h00, 6'h1a, 1'b0, 1'b0, 1'b0);
        checks++;
        if (hiloM !== (64'h1 << 36) || len !== 36) begin
            errors++;
            $display("FAIL div_hilo: HILOWrite mask %h len %0d required bit 36 only and 36", hiloM, len);
        end
        run_instr(6'h00, 6'h1a, 1'b0, 1'b0, 1'b1);
        checks++;
        if (epcM !== 64'h40 || excAtEpc !== 2'd2 || hiloM !== 64'h0) begin
            errors++;
            $display("FAIL div0_exc: EPCCtrl mask %h ExcptCtrl %0d HILOWrite mask %h required 40 2 0", epcM, excAtEpc, hiloM);
        end
    endtask

    task automatic test_reset_midway();
        logic sawHilo;
        sawHilo = 1'b0;
        bus.opCode = 6'h00;
        bus.funct = 6'h18;
        bus.div0 = 1'b0;
        repeat (10) begin
            @(negedge clk);
            sawHilo |= bus.HILOWrite;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (outs() !== '0 || sawHilo !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort: outputs %h HILOWrite seen %b required 0 0", outs(), sawHilo);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (isFetch() !== 1'b1) begin errors++; $display("FAIL midreset_fetch1: fetch %b required 1", isFetch()); end
        run_instr(6'h0f, 6'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rwM !== 64'h20 || dsAtRw !== 4'd6 || len !== 5) begin
            errors++;
            $display("FAIL midreset_lui: RegWrite mask %h DataSrc %0d len %0d required 20 6 5", rwM, dsAtRw, len);
        end
    endtask

    task automatic test_random();
        logic [11:0] table_ [18];
        logic [5:0] op, fn;
        logic ov5, eqf5, dz5;
        table_ = '{{6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h2a}, {6'h00, 6'h08}, {6'h00, 6'h10},
                   {6'h00, 6'h12}, {6'h00, 6'h00}, {6'h00, 6'h18}, {6'h00, 6'h1a}, {6'h08, 6'h3f}, {6'h23, 6'h11},
                   {6'h2b, 6'h00}, {6'h04, 6'h20}, {6'h05, 6'h00}, {6'h0f, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}};
        for (int n = 0; n < 40; n++) begin
            {op, fn} = n % 7 == 6 ? {6'h3f, 6'(n)} : n % 11 == 10 ? {6'h00, 6'h3f} : table_[$urandom_range(0, 17)];
            ov5 = 1'($urandom_range(0, 1));
            eqf5 = 1'($urandom_range(0, 1));
            dz5 = 1'($urandom_range(0, 1));
            model(op, fn, ov5, eqf5, dz5);
            run_instr(op, fn, ov5, eqf5, dz5);
            checks++;
            if (len !== eLen) begin errors++; $display("FAIL rnd_len op %h fn %h: got %0d required %0d", op, fn, len, eLen); end
            checks++;
            if (rwM !== eRw || (eRw != 0 && (rdAtRw !== eRd || dsAtRw !== eDs))) begin
                errors++;
                $display("FAIL rnd_wb op %h fn %h: mask %h RegDst %0d DataSrc %0d required %h %0d %0d", op, fn, rwM, rdAtRw, dsAtRw, eRw, eRd, eDs);
            end
            checks++;
            if (pcM !== ePc || pcSrcLast !== ePcSrc) begin
                errors++;
                $display("FAIL rnd_pc op %h fn %h: mask %h PCSrc %0d required %h %0d", op, fn, pcM, pcSrcLast, ePc, ePcSrc);
            end
            checks++;
            if (memwM !== eMemw || hiloM !== eHilo || irM !== 64'h8) begin
                errors++;
                $display("FAIL rnd_we op %h fn %h: MemCtrl %h HILOWrite %h IRWrite %h required %h %h 8", op, fn, memwM, hiloM, irM, eMemw, eHilo);
            end
            checks++;
            if (epcM !== eEpc || (eEpc != 0 && (excAtEpc !== eExc || excAtPc !== eExc))) begin
                errors++;
                $display("FAIL rnd_exc op %h fn %h: EPC mask %h cause %0d/%0d required %h %0d", op, fn, epcM, excAtEpc, excAtPc, eEpc, eExc);
            end
            checks++;
            if (conflicts !== 0) begin errors++; $display("FAIL rnd_conflict op %h fn %h: got %0d required 0", op, fn, conflicts); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_beq();
        test_lw();
        test_div();
        test_reset_midway();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end
endmodule
